// File: rtl/cla_add_scheduler.sv
// Two-requester adder that time-shares a single 4-bit carry-lookahead slice
// across all nibbles of the operands. Requests are arbitrated round-robin in
// IDLE, summed one nibble per cycle in ADD, and held in DONE until taken.
module cla_add_scheduler #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id,
    output logic         busy
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             last;

    logic             grant0;
    logic             grant1;
    logic             accept;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_g;
    logic [3:0]       slice_p;
    logic [4:0]       slice_c;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    // Round-robin grant; only offered in IDLE and never while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || last)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Status flags decode the state register and are masked during reset.
    assign rsp_valid = (state == DONE) && !rst;
    assign busy      = (state != IDLE) && !rst;

    // Next-state logic: IDLE -> ADD on accept, ADD -> DONE on last nibble,
    // DONE -> IDLE on consumer handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Select the current nibble of the latched operands for the shared slice.
    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                slice_a = a_q[n*4 +: 4];
                slice_b = b_q[n*4 +: 4];
            end
        end
    end

    // The single 4-bit carry-lookahead slice built from generate/propagate terms.
    always_comb begin
        slice_g    = slice_a & slice_b;
        slice_p    = slice_a ^ slice_b;
        slice_c[0] = carry;
        slice_c[1] = slice_g[0]
                   | (slice_p[0] & slice_c[0]);
        slice_c[2] = slice_g[1]
                   | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[3] = slice_g[2]
                   | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[4] = slice_g[3]
                   | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_sum  = slice_p ^ slice_c[3:0];
        slice_cout = slice_c[4];
    end

    // Operand capture, nibble sequencing and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            last     <= 1'b1;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= grant1 ? req1_a : req0_a;
                        b_q    <= grant1 ? req1_b : req0_b;
                        rsp_id <= grant1;
                        last   <= grant1;
                        idx    <= '0;
                        carry  <= 1'b0;
                    end
                end
                ADD: begin
                    for (int unsigned n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) begin
                            rsp_sum[n*4 +: 4] <= slice_sum;
                        end
                    end
                    carry <= slice_cout;
                    if (idx == LAST_IDX) begin
                        rsp_cout <= slice_cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
